packet_framer: RTL and testbench

//  Upstream stage of the payload buffer's Avalon-ST sink. Converts a raw, length-prefixed word

---
 rtl/packet_framer.sv | 149 ++++++++++++++
 tb/tb_packet_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// -----------------------------------------------------------------------------
// packet_framer
//   Turns a length-prefixed raw word stream into Avalon-ST packets. The stream
//   is one header word (payload length in bits [LEN_WIDTH-1:0]) followed by
//   that many payload words. Each payload word goes out through a registered
//   source port, with start/end-of-packet flags. A packet whose length is zero
//   or larger than MAX_WORDS is consumed and thrown away. The bad header is
//   counted in a saturating 16-bit drop counter.
//
// Ports
//   i_clock              clock, all logic on the rising edge
//   i_reset_n            asynchronous active-low reset
//   i_in_data            raw stream word (header or payload)
//   i_in_valid           i_in_data valid
//   o_in_ready           word accepted when i_in_valid && o_in_ready
//   o_src_data           registered Avalon-ST source data
//   o_src_valid          o_src_data valid
//   i_src_ready          downstream accepts when o_src_valid && i_src_ready
//   o_src_startofpacket  first payload word of a packet
//   o_src_endofpacket    last payload word of a packet
//   o_busy               high while a packet is in progress or output pending
//   o_drop_count         discarded packets, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module packet_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_src_data,
    output logic                  o_src_valid,
    input  logic                  i_src_ready,
    output logic                  o_src_startofpacket,
    output logic                  o_src_endofpacket,
    output logic                  o_busy,
    output logic [15:0]           o_drop_count
);

    localparam logic [1:0] ST_HEADER  = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_first;
    logic [15:0]           r_drop_count;
    logic [DATA_WIDTH-1:0] r_src_data;
    logic                  r_src_valid;
    logic                  r_sop;
    logic                  r_eop;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_last;
    logic                  w_drop_sat;
    logic [LEN_WIDTH-1:0]  w_len;

    // Payload words may only enter when the output register is free or being
    // drained this cycle; headers and dropped words never stall.
    assign w_in_ready = (r_state == ST_PAYLOAD) ? (!r_src_valid || i_src_ready) : 1'b1;
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_load     = w_accept && (r_state == ST_PAYLOAD);
    assign w_last     = (r_remaining == LEN_ONE);
    assign w_drop_sat = (r_drop_count == 16'hFFFF);
    assign w_len      = i_in_data[LEN_WIDTH-1:0];

    // Framing FSM, remaining-word counter and drop counter
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_HEADER;
            r_remaining  <= '0;
            r_first      <= 1'b0;
            r_drop_count <= 16'd0;
        end else if (w_accept) begin
            case (r_state)
                ST_HEADER: begin
                    if (w_len == '0) begin
                        if (!w_drop_sat) begin
                            r_drop_count <= r_drop_count + 16'd1;
                        end
                    end else if (w_len > MAX_LEN) begin
                        if (!w_drop_sat) begin
                            r_drop_count <= r_drop_count + 16'd1;
                        end
                        r_remaining <= w_len;
                        r_state     <= ST_DROP;
                    end else begin
                        r_remaining <= w_len;
                        r_first     <= 1'b1;
                        r_state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    r_first     <= 1'b0;
                    r_remaining <= r_remaining - LEN_ONE;
                    if (w_last) begin
                        r_state <= ST_HEADER;
                    end
                end
                ST_DROP: begin
                    r_remaining <= r_remaining - LEN_ONE;
                    if (w_last) begin
                        r_state <= ST_HEADER;
                    end
                end
                default: begin
                    r_state <= ST_HEADER;
                end
            endcase
        end
    end

    // Output register: a new load takes priority over draining, which gives
    // full throughput while the sink keeps i_src_ready high.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_src_data  <= '0;
            r_src_valid <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
        end else if (w_load) begin
            r_src_data  <= i_in_data;
            r_src_valid <= 1'b1;
            r_sop       <= r_first;
            r_eop       <= w_last;
        end else if (r_src_valid && i_src_ready) begin
            r_src_valid <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
        end
    end

    assign o_in_ready          = w_in_ready;
    assign o_src_data          = r_src_data;
    assign o_src_valid         = r_src_valid;
    assign o_src_startofpacket = r_sop;
    assign o_src_endofpacket   = r_eop;
    assign o_busy              = (r_state != ST_HEADER) || r_src_valid;
    assign o_drop_count        = r_drop_count;

endmodule

// File: tb/tb_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_packet_framer
//   Scoreboard bench for packet_framer. Each test task pushes the beats it
//   expects when it drives payload words. A monitor pops and compares every
//   source handshake. Inputs change on the falling edge. Outputs are sampled
//   between edges.
// -----------------------------------------------------------------------------
module tb_packet_framer;

    localparam int DW   = 32;
    localparam int LW   = 12;
    localparam int MAXW = 2048;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          sop;
    logic          eop;
    logic          busy;
    logic [15:0]   drop_count;

    beat_t exp_q[$];
    int    n_cmp      = 0;
    int    n_err      = 0;
    int    beats_seen = 0;
    int    exp_drop   = 0;

    always #5 clk = ~clk;

    packet_framer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .MAX_WORDS  (MAXW)
    ) dut (
        .i_clock             (clk),
        .i_reset_n           (rst_n),
        .i_in_data           (in_data),
        .i_in_valid          (in_valid),
        .o_in_ready          (in_ready),
        .o_src_data          (src_data),
        .o_src_valid         (src_valid),
        .i_src_ready         (src_ready),
        .o_src_startofpacket (sop),
        .o_src_endofpacket   (eop),
        .o_busy              (busy),
        .o_drop_count        (drop_count)
    );

    // Scoreboard monitor: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        #2;
        if (rst_n && src_valid && src_ready) begin
            got.data = src_data;
            got.sop  = sop;
            got.eop  = eop;
            beats_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b, required no beat",
                         got.data, got.sop, got.eop);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL beat: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                             got.data, got.sop, got.eop, e.data, e.sop, e.eop);
                end else begin
                    $display("beat data=%h sop=%b eop=%b ok", got.data, got.sop, got.eop);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void push_exp(input logic [DW-1:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        exp_q.push_back(b);
    endfunction

    function automatic void count_drop();
        if (exp_drop < 16'hFFFF) exp_drop++;
    endfunction

    // Call at a falling edge; returns at the falling edge after acceptance
    task automatic send_word(input logic [DW-1:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required acceptance");
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [DW-1:0] hdr, input int len,
                            input logic [DW-1:0] base, input bit good);
        send_word(hdr);
        for (int i = 0; i < len; i++) begin
            if (good) push_exp(base + DW'(i), (i == 0), (i == len - 1));
            send_word(base + DW'(i));
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL idle_timeout: got %0d beats pending busy=%b, required 0 pending busy=0",
                     exp_q.size(), busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        src_ready = 1'b1;
        #1;
        n_cmp++;
        if ({src_valid, sop, eop, busy, in_ready} !== 5'b00001 || src_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b busy=%b in_ready=%b data=%h, required 0 0 0 0 1 0",
                     src_valid, sop, eop, busy, in_ready, src_data);
        end
        n_cmp++;
        if (drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_drop: got %h, required 0000", drop_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] w;
        send_word(32'd3);
        for (int i = 0; i < 3; i++) begin
            w = 32'hA + DW'(i);
            push_exp(w, (i == 0), (i == 2));
            send_word(w);
            #1;
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== w) begin
                n_err++;
                $display("FAIL basic_latency beat %0d: got valid=%b data=%h, required valid=1 data=%h",
                         i, src_valid, src_data, w);
            end
        end
        wait_idle();
        n_cmp++;
        if (drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL basic_drop: got %h, required %h", drop_count, 16'(exp_drop));
        end
    endtask

    task automatic test_backpressure();
        int target;
        int guard;
        target = beats_seen + 2;
        guard  = 0;
        fork
            send_pkt(32'd4, 4, 32'h100, 1'b1);
            begin
                while (beats_seen < target && guard < 100) begin
                    @(negedge clk);
                    #3;
                    guard++;
                end
                n_cmp++;
                if (guard >= 100) begin
                    n_err++;
                    $display("FAIL bp_wait: got %0d beats, required %0d", beats_seen, target);
                end
                @(negedge clk);
                src_ready = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    #1;
                    n_cmp++;
                    if (in_ready !== 1'b0 || src_valid !== 1'b1 || src_data !== 32'h102 ||
                        sop !== 1'b0 || eop !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_stall cycle %0d: got in_ready=%b valid=%b data=%h sop=%b eop=%b, required 0 1 00000102 0 0",
                                 c, in_ready, src_valid, src_data, sop, eop);
                    end
                    @(negedge clk);
                end
                src_ready = 1'b1;
            end
        join
        wait_idle();
    endtask

    task automatic test_zero_len();
        send_word(32'd0);
        count_drop();
        #1;
        n_cmp++;
        if (drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL zero_len_drop: got %h, required %h", drop_count, 16'(exp_drop));
        end
        @(negedge clk);
        send_pkt(32'd1, 1, 32'h55, 1'b1);
        wait_idle();
    endtask

    task automatic test_oversize();
        int stalls;
        stalls = 0;
        send_word(32'(MAXW + 1));
        count_drop();
        #1;
        n_cmp++;
        if (busy !== 1'b1 || drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL oversize_hdr: got busy=%b drop=%h, required busy=1 drop=%h",
                     busy, drop_count, 16'(exp_drop));
        end
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < MAXW + 1; i++) begin
            in_data = DW'(i);
            #1;
            if (in_ready !== 1'b1) stalls++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (stalls != 0) begin
            n_err++;
            $display("FAIL oversize_ready: got %0d stalled words, required 0", stalls);
        end
        // Upper header bits are ignored: this is a length-2 header
        send_pkt(32'hABC0_0002, 2, 32'h200, 1'b1);
        wait_idle();
        n_cmp++;
        if (drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL oversize_drop: got %h, required %h", drop_count, 16'(exp_drop));
        end
    endtask

    task automatic test_reset_mid();
        send_word(32'd5);
        push_exp(32'h1, 1'b1, 1'b0);
        send_word(32'h1);
        send_word(32'h2);
        // Word 2 now sits in the output register; abort before it is taken
        rst_n = 1'b0;
        exp_drop = 0;
        #1;
        n_cmp++;
        if ({src_valid, busy, sop, eop} !== 4'b0000 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%b busy=%b sop=%b eop=%b drop=%h, required 0 0 0 0 0000",
                     src_valid, busy, sop, eop, drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(32'h2, 2, 32'h3, 1'b1);
        wait_idle();
    endtask

    task automatic test_saturate();
        in_data  = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            count_drop();
        end
        #1;
        n_cmp++;
        if (drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL sat_near: got %h, required %h", drop_count, 16'(exp_drop));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            count_drop();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (drop_count !== 16'(exp_drop) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sat_hold: got drop=%h busy=%b, required drop=%h busy=0",
                     drop_count, busy, 16'(exp_drop));
        end
        @(negedge clk);
        send_pkt(32'd2, 2, 32'h300, 1'b1);
        wait_idle();
        n_cmp++;
        if (drop_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_final: got %h, required ffff", drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_oversize();
        test_reset_mid();
        test_saturate();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d undelivered beats, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
